// File: rtl/aes_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : aes_job_scheduler
// Brief   : Arbitrates the shared AES datapath between the encrypt and decrypt
//           requesters, sequences key expansion / round-key load / core run,
//           and reports completion or timeout back to the owner.
// Rev     : 1.0  initial release
// ============================================================================
module aes_job_scheduler #(
  parameter int NK      = 4,
  parameter int NB      = 4,
  parameter int NR      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_enc,
  input  logic i_req_dec,
  input  logic i_key_new,
  input  logic i_ke_done,
  input  logic i_core_done_enc,
  input  logic i_core_done_dec,
  output logic o_grant_enc,
  output logic o_grant_dec,
  output logic o_ke_start,
  output logic o_w_load,
  output logic o_core_start_enc,
  output logic o_core_start_dec,
  output logic o_done_enc,
  output logic o_done_dec,
  output logic o_busy,
  output logic o_err_timeout
);

  // The counter only has to hold values up to TIMEOUT-2: the abort fires on
  // the edge that would take it to TIMEOUT-1.
  localparam int c_cnt_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT - 2);

  // Reject configurations the controller cannot honour at elaboration time.
  generate
    if (TIMEOUT < 2 || NK < 1 || NB < 1 || NR < 1) begin : g_bad_params
      $error("aes_job_scheduler: illegal parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEXP = 2'd1,
    ST_LOAD = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_grant_enc, w_grant_enc_nxt;
  logic                 r_grant_dec, w_grant_dec_nxt;
  logic                 r_ke_start, w_ke_start_nxt;
  logic                 r_w_load, w_w_load_nxt;
  logic                 r_cs_enc, w_cs_enc_nxt;
  logic                 r_cs_dec, w_cs_dec_nxt;
  logic                 r_done_enc, w_done_enc_nxt;
  logic                 r_done_dec, w_done_dec_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_err, w_err_nxt;
  logic                 r_key_valid, w_key_valid_nxt;
  logic                 r_key_stale, w_key_stale_nxt;
  logic                 r_last_enc, w_last_enc_nxt;   // 0 => last grant was dec
  logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;

  logic w_tmo;
  logic w_pick_enc;
  logic w_core_done;

  assign w_tmo       = (r_cnt == c_tmo_last);
  // Enc wins when alone, or on a tie when dec was served last.
  assign w_pick_enc  = i_req_enc & (~i_req_dec | ~r_last_enc);
  // Only the owning core's completion counts; the other one is ignored.
  assign w_core_done = r_grant_enc ? i_core_done_enc : i_core_done_dec;

  // Next-state and registered-output decode for the job sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_enc_nxt = r_grant_enc;
    w_grant_dec_nxt = r_grant_dec;
    w_ke_start_nxt  = 1'b0;
    w_w_load_nxt    = 1'b0;
    w_cs_enc_nxt    = 1'b0;
    w_cs_dec_nxt    = 1'b0;
    w_done_enc_nxt  = 1'b0;
    w_done_dec_nxt  = 1'b0;
    w_err_nxt       = r_err;
    w_key_valid_nxt = r_key_valid;
    w_key_stale_nxt = r_key_stale;
    w_last_enc_nxt  = r_last_enc;
    w_cnt_nxt       = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (i_key_new) w_key_valid_nxt = 1'b0;
        if (i_req_enc | i_req_dec) begin
          w_grant_enc_nxt = w_pick_enc;
          w_grant_dec_nxt = ~w_pick_enc;
          w_last_enc_nxt  = w_pick_enc;
          w_err_nxt       = 1'b0;
          w_cnt_nxt       = '0;
          // A key change arriving with the request forces re-expansion.
          if (r_key_valid & ~i_key_new) begin
            w_state_nxt  = ST_RUN;
            w_cs_enc_nxt = w_pick_enc;
            w_cs_dec_nxt = ~w_pick_enc;
          end else begin
            w_state_nxt    = ST_KEXP;
            w_ke_start_nxt = 1'b1;
          end
        end
      end

      ST_KEXP: begin
        if (i_key_new) w_key_stale_nxt = 1'b1;
        if (i_ke_done) begin
          w_state_nxt  = ST_LOAD;
          w_w_load_nxt = 1'b1;
        end else if (w_tmo) begin
          w_state_nxt     = ST_IDLE;
          w_grant_enc_nxt = 1'b0;
          w_grant_dec_nxt = 1'b0;
          w_key_valid_nxt = 1'b0;
          w_key_stale_nxt = 1'b0;
          w_err_nxt       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end

      ST_LOAD: begin
        // Keys become valid now; a key_new seen during the job still
        // invalidates them once the job returns to idle.
        if (i_key_new) w_key_stale_nxt = 1'b1;
        w_key_valid_nxt = 1'b1;
        w_state_nxt     = ST_RUN;
        w_cnt_nxt       = '0;
        w_cs_enc_nxt    = r_grant_enc;
        w_cs_dec_nxt    = r_grant_dec;
      end

      ST_RUN: begin
        if (i_key_new) w_key_stale_nxt = 1'b1;
        if (w_core_done) begin
          w_state_nxt     = ST_IDLE;
          w_done_enc_nxt  = r_grant_enc;
          w_done_dec_nxt  = r_grant_dec;
          w_grant_enc_nxt = 1'b0;
          w_grant_dec_nxt = 1'b0;
          if (r_key_stale | i_key_new) w_key_valid_nxt = 1'b0;
          w_key_stale_nxt = 1'b0;
        end else if (w_tmo) begin
          w_state_nxt     = ST_IDLE;
          w_grant_enc_nxt = 1'b0;
          w_grant_dec_nxt = 1'b0;
          w_key_valid_nxt = 1'b0;
          w_key_stale_nxt = 1'b0;
          w_err_nxt       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers; reset returns everything to idle at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_grant_enc <= 1'b0;
      r_grant_dec <= 1'b0;
      r_ke_start  <= 1'b0;
      r_w_load    <= 1'b0;
      r_cs_enc    <= 1'b0;
      r_cs_dec    <= 1'b0;
      r_done_enc  <= 1'b0;
      r_done_dec  <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_stale <= 1'b0;
      r_last_enc  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_enc <= w_grant_enc_nxt;
      r_grant_dec <= w_grant_dec_nxt;
      r_ke_start  <= w_ke_start_nxt;
      r_w_load    <= w_w_load_nxt;
      r_cs_enc    <= w_cs_enc_nxt;
      r_cs_dec    <= w_cs_dec_nxt;
      r_done_enc  <= w_done_enc_nxt;
      r_done_dec  <= w_done_dec_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_stale <= w_key_stale_nxt;
      r_last_enc  <= w_last_enc_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign o_grant_enc      = r_grant_enc;
  assign o_grant_dec      = r_grant_dec;
  assign o_ke_start       = r_ke_start;
  assign o_w_load         = r_w_load;
  assign o_core_start_enc = r_cs_enc;
  assign o_core_start_dec = r_cs_dec;
  assign o_done_enc       = r_done_enc;
  assign o_done_dec       = r_done_dec;
  assign o_busy           = r_busy;
  assign o_err_timeout    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_job_scheduler
// Brief   : Directed scoreboard bench for aes_job_scheduler. Stimulus pushes
//           expected pulses/levels tagged with the edge index they belong to;
//           a negedge monitor pops and compares them.
// Rev     : 1.0  initial release
// ============================================================================
module tb_aes_job_scheduler;

  localparam int TIMEOUT = 64;

  localparam int EV_KE = 0, EV_WL = 1, EV_CSE = 2, EV_CSD = 3, EV_DE = 4, EV_DD = 5;
  localparam int L_GE = 0, L_GD = 1, L_BUSY = 2, L_ERR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_enc = 1'b0, req_dec = 1'b0, key_new = 1'b0, ke_done = 1'b0;
  logic cd_enc = 1'b0, cd_dec = 1'b0;
  logic grant_enc, grant_dec, ke_start, w_load, cs_enc, cs_dec;
  logic done_enc, done_dec, busy, err_timeout;

  int cyc = 0;
  int vectors = 0;
  int fails = 0;

  typedef struct { int cyc; int code; } pev_t;
  typedef struct { int cyc; int sig; logic val; } lev_t;
  pev_t pq[$];
  lev_t lq[$];

  aes_job_scheduler #(.NK(4), .NB(4), .NR(10), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_enc(req_enc), .i_req_dec(req_dec), .i_key_new(key_new),
    .i_ke_done(ke_done), .i_core_done_enc(cd_enc), .i_core_done_dec(cd_dec),
    .o_grant_enc(grant_enc), .o_grant_dec(grant_dec),
    .o_ke_start(ke_start), .o_w_load(w_load),
    .o_core_start_enc(cs_enc), .o_core_start_dec(cs_dec),
    .o_done_enc(done_enc), .o_done_dec(done_dec),
    .o_busy(busy), .o_err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Edge index: after the Nth rising edge, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string pname(int k);
    case (k)
      EV_KE:   return "ke_start";
      EV_WL:   return "w_load";
      EV_CSE:  return "core_start_enc";
      EV_CSD:  return "core_start_dec";
      EV_DE:   return "done_enc";
      default: return "done_dec";
    endcase
  endfunction

  function automatic string lname(int s);
    case (s)
      L_GE:    return "grant_enc";
      L_GD:    return "grant_dec";
      L_BUSY:  return "busy";
      default: return "err_timeout";
    endcase
  endfunction

  function automatic logic lval(int s);
    case (s)
      L_GE:    return grant_enc;
      L_GD:    return grant_dec;
      L_BUSY:  return busy;
      default: return err_timeout;
    endcase
  endfunction

  task automatic push_p(input int c, input int code);
    pev_t e;
    e.cyc = c; e.code = code;
    pq.push_back(e);
  endtask

  task automatic push_l(input int c, input int sig, input logic v);
    lev_t e;
    e.cyc = c; e.sig = sig; e.val = v;
    lq.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: compare every expected pulse/level due at this edge, flag any
  // unexpected pulse, and watch the one-hot grant and single-cycle pulses.
  logic [5:0] prev_act = '0;
  always @(negedge clk) begin
    logic [5:0] act;
    bit hit;
    act = {done_dec, done_enc, cs_dec, cs_enc, w_load, ke_start};
    for (int k = 0; k < 6; k++) begin
      hit = 1'b0;
      for (int i = 0; i < pq.size(); i++) begin
        if (pq[i].cyc == cyc && pq[i].code == k) begin
          hit = 1'b1;
          pq.delete(i);
          break;
        end
      end
      if (hit || act[k]) begin
        vectors++;
        if (act[k] !== hit) begin
          fails++;
          $display("FAIL pulse %s at edge %0d: got %0b want %0b", pname(k), cyc, act[k], hit);
        end
      end
    end
    for (int i = lq.size() - 1; i >= 0; i--) begin
      if (lq[i].cyc == cyc) begin
        vectors++;
        if (lval(lq[i].sig) !== lq[i].val) begin
          fails++;
          $display("FAIL level %s at edge %0d: got %0b want %0b",
                   lname(lq[i].sig), cyc, lval(lq[i].sig), lq[i].val);
        end
        lq.delete(i);
      end
    end
    vectors++;
    if ((grant_enc & grant_dec) !== 1'b0 || (act & prev_act) !== 6'b0) begin
      fails++;
      $display("FAIL invariant at edge %0d: grants %0b%0b pulses %b prev %b",
               cyc, grant_enc, grant_dec, act, prev_act);
    end
    prev_act = act;
  end

  // One job: request already set so it is sampled at edge N = cyc+1.
  // kexp selects the expansion path; kn_at > 0 pulses key_new at edge S+kn_at.
  task automatic job(input bit enc, input bit kexp, input int ke_lat,
                     input int core_lat, input int kn_at);
    int n, k, s, m;
    int gsig, osig;
    n = cyc + 1;
    gsig = enc ? L_GE : L_GD;
    osig = enc ? L_GD : L_GE;
    push_l(n, gsig, 1'b1);
    push_l(n, osig, 1'b0);
    push_l(n, L_BUSY, 1'b1);
    push_l(n, L_ERR, 1'b0);
    if (kexp) begin
      push_p(n, EV_KE);
      k = n + ke_lat;
      push_p(k, EV_WL);
      s = k + 1;
    end else begin
      k = n;
      s = n;
    end
    push_p(s, enc ? EV_CSE : EV_CSD);
    m = s + core_lat;
    push_p(m, enc ? EV_DE : EV_DD);
    push_l(m - 1, gsig, 1'b1);
    push_l(m, gsig, 1'b0);
    push_l(m, L_BUSY, 1'b0);
    @(negedge clk);
    key_new = 1'b0;
    if (kexp) begin
      wait_until(k - 1); ke_done = 1'b1;
      wait_until(k);     ke_done = 1'b0;
    end
    if (kn_at > 0) begin
      wait_until(s + kn_at - 1); key_new = 1'b1;
      wait_until(s + kn_at);     key_new = 1'b0;
    end
    wait_until(m - 1);
    if (enc) cd_enc = 1'b1; else cd_dec = 1'b1;
    wait_until(m);
    cd_enc = 1'b0;
    cd_dec = 1'b0;
  endtask

  initial begin
    int n, p;
    // Reset state.
    repeat (3) @(negedge clk);
    push_l(cyc + 1, L_GE, 1'b0);
    push_l(cyc + 1, L_GD, 1'b0);
    push_l(cyc + 1, L_BUSY, 1'b0);
    push_l(cyc + 1, L_ERR, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Uncached enc job, then a cached one.
    req_enc = 1'b1; job(1, 1, 5, 12, 0); req_enc = 1'b0;
    repeat (2) @(negedge clk);
    req_enc = 1'b1; job(1, 0, 0, 4, 0); req_enc = 1'b0;
    repeat (2) @(negedge clk);

    // Tie after reset: enc, then dec at M+1, then enc again.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req_enc = 1'b1; req_dec = 1'b1;
    job(1, 1, 2, 3, 0);
    job(0, 0, 0, 3, 0);
    job(1, 0, 0, 2, 0);
    req_enc = 1'b0; req_dec = 1'b0;
    repeat (2) @(negedge clk);

    // key_new during RUN: no KEXP now, KEXP on the next job.
    req_enc = 1'b1; job(1, 0, 0, 6, 2); req_enc = 1'b0;
    @(negedge clk);
    req_enc = 1'b1; job(1, 1, 3, 3, 0); req_enc = 1'b0;
    @(negedge clk);
    // key_new on the request edge forces expansion.
    req_enc = 1'b1; key_new = 1'b1; job(1, 1, 1, 2, 0); req_enc = 1'b0;
    @(negedge clk);

    // Timeout in KEXP (keys invalidated with the request).
    req_dec = 1'b1; key_new = 1'b1;
    n = cyc + 1;
    push_p(n, EV_KE);
    push_l(n, L_GD, 1'b1);
    push_l(n + TIMEOUT - 2, L_GD, 1'b1);
    push_l(n + TIMEOUT - 2, L_ERR, 1'b0);
    push_l(n + TIMEOUT - 1, L_GD, 1'b0);
    push_l(n + TIMEOUT - 1, L_ERR, 1'b1);
    push_l(n + TIMEOUT - 1, L_BUSY, 1'b0);
    @(negedge clk);
    key_new = 1'b0;
    wait_until(n + TIMEOUT - 2);
    req_dec = 1'b0;
    wait_until(n + TIMEOUT - 1);
    push_l(cyc + 2, L_ERR, 1'b1);
    repeat (2) @(negedge clk);
    req_enc = 1'b1; job(1, 1, 2, 2, 0); req_enc = 1'b0;
    @(negedge clk);

    // Asynchronous reset during RUN discards the job.
    req_enc = 1'b1;
    n = cyc + 1;
    push_p(n, EV_CSE);
    push_l(n, L_GE, 1'b1);
    wait_until(n + 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cd_enc = 1'b1;
    req_enc = 1'b0;
    p = cyc;
    push_l(p, L_GE, 1'b0);
    push_l(p, L_GD, 1'b0);
    push_l(p, L_BUSY, 1'b0);
    push_l(p, L_ERR, 1'b0);
    repeat (2) @(negedge clk);
    cd_enc = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    req_dec = 1'b1; job(0, 1, 3, 3, 0); req_dec = 1'b0;

    repeat (3) @(negedge clk);
    foreach (pq[i]) begin
      vectors++; fails++;
      $display("FAIL pending pulse %s for edge %0d: got unchecked want checked", pname(pq[i].code), pq[i].cyc);
    end
    foreach (lq[i]) begin
      vectors++; fails++;
      $display("FAIL pending level %s for edge %0d: got unchecked want checked", lname(lq[i].sig), lq[i].cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/aes_job_scheduler.md
# aes_job_scheduler

Sequencing and arbitration controller for the shared AES datapath: one keyExpansion instance, one round-key register bank and one encryption core plus one decryption core. It grants exactly one requester (encrypt or decrypt SPI subnode) at a time. It skips key expansion when the cached round keys are still valid. It pulses keyExpansion start, round-key load and core start, and reports completion or timeout back to the requester.

## Interface
Parameters:
- nk, 4, key length in 32-bit words (passed through to size nothing internal but kept for instantiation symmetry)
- nb, 4, block size in words
- nr, 10, round count
- TIMEOUT, 64, max cycles allowed in KEXP or RUN before abort (≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_enc  in  1  encrypt job request, level, held until done_enc
- req_dec  in  1  decrypt job request, level, held until done_dec
- key_new  in  1  one-cycle pulse: key_in changed, cached round keys invalid
- ke_done  in  1  keyExpansion out_valid (level acceptable)
- core_done_enc  in  1  encryption core out_valid
- core_done_dec  in  1  decryption core out_valid
- grant_enc / grant_dec  out  1  ownership of datapath, one-hot or zero
- ke_start  out  1  one-cycle pulse to keyExpansion in_valid
- w_load  out  1  one-cycle pulse: latch w into round-key register
- core_start_enc / core_start_dec  out  1  one-cycle core in_valid pulse
- done_enc / done_dec  out  1  one-cycle completion pulse to requester
- busy  out  1  high whenever state ≠ IDLE
- err_timeout  out  1  sticky abort flag

## Operation
- States: IDLE, KEXP, LOAD, RUN.
- Internal regs: key_valid (reset 0), key_stale (reset 0), last_grant (reset = dec, so enc wins the first tie), timeout counter.
- IDLE: if any req high, arbitrate.
  - Single requester: that one wins.
  - Both: the requester other than last_grant wins; last_grant updates.
  - Winner's grant set. If key_valid, go to RUN. Otherwise go to KEXP.
- KEXP: ke_start pulsed on entry. Wait for ke_done, then go to LOAD.
- LOAD: w_load pulsed for one cycle, key_valid←1. Go to RUN.
- RUN: the granted core's core_start pulsed on entry. Wait for the matching core_done (the other core_done is ignored).
  - On core_done: done pulse to the granted requester, grant cleared, go to IDLE.
- key_new:
  - In IDLE: clears key_valid immediately. A key_new on the same edge as arbitration takes priority, so the job goes through KEXP.
  - While busy: sets key_stale. The current job finishes with the old round keys. On return to IDLE, key_valid←0 and key_stale←0.
- Timeout:
  - Counter clears on entry to KEXP/RUN and increments each cycle in those states.
  - Reaching TIMEOUT−1 without the awaited done aborts: state←IDLE, grant cleared, key_valid←0, err_timeout←1, no done pulse.
  - err_timeout clears on the next grant.
- A req falling mid-job is ignored; the job runs to completion.
- req still high on the edge after its done is treated as a new request.

## Timing
- Reset (async assert):
  - All outputs 0.
  - state IDLE, key_valid 0, key_stale 0, last_grant dec, counter 0.
- Mid-job reset: immediate return to reset values; no done pulse; the core's output is discarded.
- All outputs are registered, set on the edge that performs the transition.
- Cached-key job, req sampled at edge N:
  - grant and core_start high after N.
  - core_start low after N+1.
  - core_done sampled at edge M gives done high for cycle M..M+1, with grant low after M.
- Uncached job:
  - grant and ke_start after edge N.
  - ke_done at edge K gives w_load after K.
  - core_start after K+1.
- Minimum one IDLE cycle between jobs; earliest re-arbitration is edge M+1.
- ke_start, w_load, core_start and done are never high for more than one consecutive cycle.
- grant_enc & grant_dec is never 1.

## Test plan
- Reset, then req_enc with key_valid=0; ke_done 5 cycles after ke_start; core_done_enc 12 cycles after core_start -> ke_start, w_load, core_start_enc and done_enc each fire exactly once. grant_enc is high from N+1 through the done edge.
- Second req_enc with no key_new -> no ke_start; core_start_enc one cycle after the request edge.
- req_enc and req_dec high on the same edge after reset -> enc granted first. On enc completion with both still requesting, dec is granted at M+1, then enc again.
- key_new pulsed during RUN -> current job completes without KEXP; the next job issues ke_start. key_new on the same edge as a request in IDLE -> KEXP taken.
- Hold ke_done=0 with TIMEOUT=64 -> abort 63 cycles after KEXP entry: err_timeout=1, grant=0, no done. The next request re-expands and clears err_timeout on grant.
- Assert rst low during RUN -> all outputs 0 asynchronously. After release, req_dec triggers a full KEXP path because key_valid was reset.
